// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - two-requester round-robin front end sequencing an RLS803 barrel shifter
module shift_sequencer #(
  parameter int WIDTH     = 8,
  parameter int SH_AMT_W  = 3,
  parameter int REQ_AMT_W = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [WIDTH-1:0]     req0_data,
  input  logic [REQ_AMT_W-1:0] req0_amt,
  input  logic                 req0_dir,
  input  logic [WIDTH-1:0]     req1_data,
  input  logic [REQ_AMT_W-1:0] req1_amt,
  input  logic                 req1_dir,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [WIDTH-1:0]     resp_data,
  output logic                 resp_id,
  output logic [WIDTH-1:0]     sh_data_in,
  output logic [SH_AMT_W-1:0]  sh_shift_amt,
  output logic                 sh_direction,
  output logic                 sh_clear_n,
  input  logic [WIDTH-1:0]     sh_data_out
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_LD   = 3'd2,
    S_SHF  = 3'd3,
    S_CAP  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  // Largest amount the shifter takes in one cycle, expressed in request-amount width.
  localparam logic [REQ_AMT_W-1:0] MAX_STEP = REQ_AMT_W'((1 << SH_AMT_W) - 1);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [REQ_AMT_W-1:0] rem_q, rem_d;
  logic                 dir_q, dir_d;
  logic                 id_q, id_d;
  logic                 last_grant_q, last_grant_d;
  logic [WIDTH-1:0]     resp_data_q, resp_data_d;
  logic                 resp_id_q, resp_id_d;

  logic                 any_valid;
  logic                 win_id;
  logic                 accept;
  logic [SH_AMT_W-1:0]  step_amt;
  logic [REQ_AMT_W-1:0] step_ext;
  logic                 last_step;

  // Round-robin arbiter: on a tie the requester that did not win last time goes first.
  always_comb begin
    any_valid = |req_valid;
    win_id    = 1'b0;
    if (req_valid == 2'b11) begin
      win_id = ~last_grant_q;
    end else if (req_valid[1]) begin
      win_id = 1'b1;
    end
  end

  assign accept = |(req_valid & req_ready);

  // Split the remaining amount into shifter-sized steps; the last step empties rem exactly.
  always_comb begin
    if (rem_q > MAX_STEP) begin
      step_amt = MAX_STEP[SH_AMT_W-1:0];
    end else begin
      step_amt = rem_q[SH_AMT_W-1:0];
    end
    step_ext  = {{(REQ_AMT_W-SH_AMT_W){1'b0}}, step_amt};
    last_step = (rem_q <= MAX_STEP);
  end

  // State register; clear drops any in-flight operation and re-arms req0 for the first tie.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      rem_q        <= '0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      rem_q        <= rem_d;
      dir_q        <= dir_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
    end
  end

  // Next-state logic: clear, load, zero or more shift steps, capture, then hold for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CLR;
      S_CLR:  state_d = S_LD;
      S_LD:   state_d = (rem_q == '0) ? S_CAP : S_SHF;
      S_SHF:  if (last_step) state_d = S_CAP;
      S_CAP:  state_d = S_RESP;
      S_RESP: if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Operand latching, remaining-amount countdown and result capture.
  always_comb begin
    data_d       = data_q;
    rem_d        = rem_q;
    dir_d        = dir_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    if (accept) begin
      data_d       = win_id ? req1_data : req0_data;
      rem_d        = win_id ? req1_amt  : req0_amt;
      dir_d        = win_id ? req1_dir  : req0_dir;
      id_d         = win_id;
      last_grant_d = win_id;
    end
    if (state_q == S_SHF) begin
      rem_d = rem_q - step_ext;
    end
    if (state_q == S_CAP) begin
      resp_data_d = sh_data_out;
      resp_id_d   = id_q;
    end
  end

  // Outputs decoded from state; the shifter is held cleared whenever no operation is running.
  always_comb begin
    req_ready    = 2'b00;
    resp_valid   = 1'b0;
    sh_clear_n   = 1'b0;
    sh_shift_amt = '0;
    sh_direction = 1'b0;
    sh_data_in   = '0;
    case (state_q)
      S_IDLE: begin
        if (!clear && any_valid) begin
          req_ready = win_id ? 2'b10 : 2'b01;
        end
      end
      S_LD: begin
        sh_clear_n = 1'b1;
        sh_data_in = data_q;
      end
      S_SHF: begin
        sh_clear_n   = 1'b1;
        sh_shift_amt = step_amt;
        sh_direction = dir_q;
      end
      S_CAP: begin
        sh_clear_n = 1'b1;
      end
      S_RESP: begin
        resp_valid = 1'b1;
      end
      default: begin
        req_ready = 2'b00;
      end
    endcase
  end

  assign resp_data = resp_data_q;
  assign resp_id   = resp_id_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer with an RLS803 behavioural model
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] req_ready;
  logic [7:0] req0_data = 8'h00;
  logic [3:0] req0_amt = 4'h0;
  logic       req0_dir = 1'b0;
  logic [7:0] req1_data = 8'h00;
  logic [3:0] req1_amt = 4'h0;
  logic       req1_dir = 1'b0;
  logic       resp_valid;
  logic       resp_ready = 1'b1;
  logic [7:0] resp_data;
  logic       resp_id;
  logic [7:0] sh_data_in;
  logic [2:0] sh_shift_amt;
  logic       sh_direction;
  logic       sh_clear_n;
  logic [7:0] sh_data_out;

  shift_sequencer dut (
    .clk          (clk),
    .clear        (clear),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req0_data    (req0_data),
    .req0_amt     (req0_amt),
    .req0_dir     (req0_dir),
    .req1_data    (req1_data),
    .req1_amt     (req1_amt),
    .req1_dir     (req1_dir),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_id      (resp_id),
    .sh_data_in   (sh_data_in),
    .sh_shift_amt (sh_shift_amt),
    .sh_direction (sh_direction),
    .sh_clear_n   (sh_clear_n),
    .sh_data_out  (sh_data_out)
  );

  always #5 clk = ~clk;

  // RLS803 model: cleared by clear_n, otherwise ORs data_in into the register and shifts it.
  logic [7:0] sh_reg = 8'h00;
  always @(posedge clk) begin
    if (!sh_clear_n) sh_reg <= 8'h00;
    else if (sh_direction) sh_reg <= (sh_reg | sh_data_in) << sh_shift_amt;
    else sh_reg <= (sh_reg | sh_data_in) >> sh_shift_amt;
  end
  assign sh_data_out = sh_reg;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       id;
    logic [7:0] data;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] steps[$];
  logic       ids[$];
  int tests = 0;
  int fails = 0;
  int n_acc = 0;
  int n_resp = 0;
  int rv_seen = 0;
  int acc_edge = 0;
  logic rv_prev = 1'b0;

  function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic [3:0] a, input logic dir);
    logic [7:0] r;
    if (dir) r = d << a;
    else r = d >> a;
    return r;
  endfunction

  function automatic int ref_lat(input logic [3:0] a);
    if (a == 4'd0) return 3;
    return 3 + (int'(a) + 6) / 7;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests++;
    fails++;
    $error("FAIL %s: observed timeout expected event", tag);
  endtask

  // One cycle: sample 2ns after the negedge, record acceptances/responses, advance to next negedge.
  task automatic tick();
    exp_t e;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        e.id   = i[0];
        e.data = (i == 1) ? ref_shift(req1_data, req1_amt, req1_dir) : ref_shift(req0_data, req0_amt, req0_dir);
        e.lat  = (i == 1) ? ref_lat(req1_amt) : ref_lat(req0_amt);
        sb.push_back(e);
        acc_edge = cyc + 1;
        n_acc++;
      end
    end
    if (sh_shift_amt != 3'd0) steps.push_back(sh_shift_amt);
    if (resp_valid) rv_seen++;
    if (resp_valid && !rv_prev && sb.size() > 0) check("latency", cyc - acc_edge, sb[0].lat);
    if (resp_valid && resp_ready) begin
      if (sb.size() == 0) begin
        timeout("unexpected_resp");
      end else begin
        e = sb.pop_front();
        check("resp_data", resp_data, e.data);
        check("resp_id", resp_id, e.id);
        ids.push_back(resp_id);
      end
      n_resp++;
    end
    rv_prev = resp_valid;
    @(negedge clk);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (n_acc < target && n < 60) begin tick(); n++; end
    if (n_acc < target) timeout("wait_acc");
  endtask

  task automatic wait_resp(input int target);
    int n = 0;
    while (n_resp < target && n < 60) begin tick(); n++; end
    if (n_resp < target) timeout("wait_resp");
  endtask

  task automatic single(input logic id, input logic [7:0] d, input logic [3:0] a, input logic dir);
    int ta;
    int tr;
    if (id) begin req1_data = d; req1_amt = a; req1_dir = dir; end
    else begin req0_data = d; req0_amt = a; req0_dir = dir; end
    req_valid[id] = 1'b1;
    steps.delete();
    ta = n_acc + 1;
    tr = n_resp + 1;
    wait_acc(ta);
    req_valid[id] = 1'b0;
    wait_resp(tr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int n;
    int exp_ids[3] = '{0, 1, 0};

    // Reset with both requesters already valid.
    req_valid = 2'b11;
    req0_data = 8'h81; req0_amt = 4'd1; req0_dir = 1'b0;
    req1_data = 8'h81; req1_amt = 4'd1; req1_dir = 1'b1;
    #1 clear = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_data", resp_data, 8'h00);
    check("rst_resp_id", resp_id, 1'b0);
    check("rst_sh_clear_n", sh_clear_n, 1'b0);
    check("rst_sh_shift_amt", sh_shift_amt, 3'd0);
    check("rst_sh_direction", sh_direction, 1'b0);
    check("rst_sh_data_in", sh_data_in, 8'h00);
    clear = 1'b0;

    // T4: both valid continuously, grants alternate starting with req0.
    ids.delete();
    wait_resp(3);
    req_valid = 2'b00;
    check("t4_count", ids.size(), 3);
    for (int i = 0; i < 3 && i < ids.size(); i++) check("t4_order", ids[i], exp_ids[i]);

    // T1: right shift by 2.
    single(1'b0, 8'hAA, 4'd2, 1'b0);
    check("t1_steps", steps.size(), 1);

    // T2: left shift by 3 from req1 in one step.
    single(1'b1, 8'hAA, 4'd3, 1'b1);
    check("t2_steps", steps.size(), 1);
    if (steps.size() > 0) check("t2_step0", steps[0], 3'd3);

    // T3: amount 10 splits into 7 then 3.
    single(1'b0, 8'hF0, 4'd10, 1'b0);
    check("t3_steps", steps.size(), 2);
    if (steps.size() > 1) begin
      check("t3_step0", steps[0], 3'd7);
      check("t3_step1", steps[1], 3'd3);
    end

    // T3: amount 0 skips shifting.
    single(1'b0, 8'hAA, 4'd0, 1'b1);
    check("t3_zero_steps", steps.size(), 0);

    // Left shift past the width yields zero.
    single(1'b1, 8'hFF, 4'd9, 1'b1);

    // T6: clear during the first shift step of an amount-10 operation.
    req0_data = 8'hF0; req0_amt = 4'd10; req0_dir = 1'b0;
    req_valid[0] = 1'b1;
    t = n_acc + 1;
    wait_acc(t);
    req_valid[0] = 1'b0;
    tick();
    tick();
    check("t6_in_shf", sh_shift_amt, 3'd7);
    clear = 1'b1;
    #1;
    check("t6_sh_clear_n", sh_clear_n, 1'b0);
    check("t6_sh_shift_amt", sh_shift_amt, 3'd0);
    check("t6_resp_valid", resp_valid, 1'b0);
    sb.delete();
    @(negedge clk);
    clear = 1'b0;
    rv_prev = 1'b0;
    n = rv_seen;
    for (int i = 0; i < 8; i++) tick();
    check("t6_no_resp", rv_seen - n, 0);
    single(1'b1, 8'h3C, 4'd2, 1'b0);

    // T5: consumer stalls 5 cycles; req1 also waiting must not be accepted meanwhile.
    resp_ready = 1'b0;
    req0_data = 8'h0F; req0_amt = 4'd1; req0_dir = 1'b1;
    req1_data = 8'h80; req1_amt = 4'd7; req1_dir = 1'b0;
    req_valid = 2'b11;
    t = n_acc + 1;
    wait_acc(t);
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid && n < 30) begin tick(); n++; end
    if (!resp_valid) timeout("t5_resp_valid");
    for (int i = 0; i < 5; i++) begin
      check("t5_valid_held", resp_valid, 1'b1);
      check("t5_data_stable", resp_data, 8'h1E);
      check("t5_id_stable", resp_id, 1'b0);
      check("t5_no_ready", req_ready, 2'b00);
      tick();
    end
    resp_ready = 1'b1;
    t = n_acc + 1;
    n = n_resp + 2;
    wait_acc(t);
    req_valid[1] = 1'b0;
    wait_resp(n);
    check("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
